instruction_encoder: RTL and testbench
======================================

Name: instruction_encoder

Overview:
Inverse of the CPU's instruction-name decode. It accepts a stream of symbolic instructions: an instruction_type plus rd/rs1/rs2/imm fields. Each one is encoded into an RV32I machine word, buffered in a small FIFO, and written sequentially into instruction memory starting at a programmable word address. It is used by the program loader and test infrastructure to build programs in IMEM without an external assembler.

Parameters:
ADDR_W, 12, IMEM word-address width; the address counter wraps modulo 2^ADDR_W.
FIFO_DEPTH, 4, encoded-word buffer depth; power of two, minimum 2.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: begin a program load (honoured only in IDLE)
start_addr  input  ADDR_W  first IMEM word address, sampled on start
in_valid  input  1  instruction request valid
in_ready  output  1  encoder can accept the request
in_inst  input  instruction_type  instruction to encode
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_imm  input  32  immediate, as a byte-offset / value, sign already applied
in_last  input  1  marks the final instruction of the program
mem_we  output  1  IMEM write request
mem_ready  input  1  IMEM accepts the write this cycle
mem_addr  output  ADDR_W  IMEM word address
mem_wdata  output  32  encoded instruction word
busy  output  1  state != IDLE
done  output  1  one-cycle pulse after the last word is written
err_invalid  output  1  sticky: an INVALID instruction was submitted
words_written  output  ADDR_W+1  count of words written since start

Behaviour:
- Reset (synchronous) drives every output to 0. It empties the FIFO, sets state IDLE and clears err_invalid and words_written. Reset mid-load abandons the load; no further mem_we is asserted.
- FSM states and transitions:
  - IDLE -> ACTIVE on start. start_addr is latched into the address counter; words_written is cleared to 0.
  - ACTIVE -> DRAIN when a request is accepted with in_last=1.
  - DRAIN -> DONE when the FIFO is empty and no write is pending.
  - DONE -> IDLE unconditionally after 1 cycle; done=1 only in DONE.
  - start outside IDLE is ignored.
- in_ready = (state==ACTIVE) && FIFO not full. There is no full-bypass: a push and a pop in the same cycle are allowed only when the FIFO is not full.
- A request is accepted when in_valid && in_ready. The encoding is combinational on the inputs, and the word is registered into the FIFO. The earliest mem_we is the cycle after acceptance (latency 1).
- mem_we = FIFO not empty. mem_addr and mem_wdata come from the counter and the FIFO head. All three are held stable while mem_ready=0.
- A write completes on mem_we && mem_ready. On completion: pop the FIFO, addr <= addr+1 (wrapping from 2^ADDR_W-1 to 0), words_written += 1.
- INVALID in_inst: the request is accepted (handshake completes) and nothing is pushed; err_invalid is set to 1 and holds until rst. If in_last=1 on an INVALID request, the FSM still moves to DRAIN.
- Encoding rules, using the standard RV32I fields:
  - R-type: funct7 0x20 for SUB/SRA, otherwise 0x00.
  - I-type: imm[11:0].
  - Shift-immediates: shamt = imm[4:0], funct7 0x20 for SRAI, otherwise 0x00.
  - S-type: imm[11:5] | imm[4:0].
  - B-type: imm[12|10:5|4:1|11]; imm[0] is ignored.
  - U-type: imm[31:12].
  - J-type: imm[20|10:1|11|19:12]; imm[0] is ignored.
  - Fields unused by a format are forced to 0.
  - NOP -> 32'h00000013; ECALL -> 32'h00000073; all other fields are ignored for these two.
- Round-trip invariant: the existing instruction-name decode applied to mem_wdata equals the in_inst that produced it, for every non-INVALID type.

Decomposition:
- common_def package gains:
  - opcode constants (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_SYSTEM);
  - funct3/funct7 constants;
  - NOP_WORD and ECALL_WORD;
  - the encoder FSM state enum.
- The existing instruction_type enum is reused unchanged.
- One sub-module, inst_word_fifo: a synchronous FIFO of width 32 and depth FIFO_DEPTH with push/pop/full/empty and synchronous reset.
- Encoding is a combinational block inside instruction_encoder.

Test Plan:
- start with start_addr=0x010, then ADDI rd=1 rs1=0 imm=5 with in_last=1, mem_ready=1 -> mem_we at addr 0x010 with wdata 0x00500093; done pulses 2 cycles later; words_written=1.
- Stream SW rs1=1 rs2=2 imm=8; LUI rd=5 imm=0x12345000; BEQ rs1=1 rs2=2 imm=-4; SRAI rd=3 rs1=4 imm=7 -> words 0x0020A423, 0x123452B7, 0xFE208EE3, 0x40725193 at consecutive addresses.
- Hold mem_ready=0 while pushing 5 requests (FIFO_DEPTH=4) -> in_ready drops after 4 accepts, and mem_addr/mem_wdata stay stable. Releasing mem_ready drains all 5 in order.
- start_addr=0xFFF, then two instructions -> writes land at 0xFFF then 0x000; words_written=2.
- Submit an INVALID instruction between two NOPs -> two 0x00000013 writes only; err_invalid=1 and persists after done.
- Assert rst while the FIFO holds 3 words -> the next cycle has mem_we=0, busy=0, in_ready=0 and err_invalid=0. A fresh start works normally.

Source files
------------

// File: rtl/common_def.sv
// ---------------------------------------------------------------------------
// common_def
// Shared definitions for the RV32I instruction encoder:
//   - instruction_type : symbolic instruction names (also used by the decoder)
//   - OPC_* / F3_* / F7_* : RV32I opcode and function-field constants
//   - NOP_WORD, ECALL_WORD : fixed encodings
//   - inst_fmt_t  : RV32I encoding format selector
//   - enc_state_t : program-load FSM states
// ---------------------------------------------------------------------------
package common_def;

    typedef enum logic [5:0] {
        INVALID,
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        NOP, ECALL
    } instruction_type;

    // Major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // funct3: ALU (shared by OP and OP-IMM)
    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;
    // funct3: branches
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;
    // funct3: memory access width (loads and stores)
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam logic [2:0] F3_JALR = 3'd0;

    // funct7
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;   // SUB, SRA, SRAI

    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_FIXED
    } inst_fmt_t;

    typedef enum logic [1:0] {
        IDLE, ACTIVE, DRAIN, DONE
    } enc_state_t;

endpackage

// File: rtl/inst_word_fifo.sv
// ---------------------------------------------------------------------------
// inst_word_fifo
// Synchronous FIFO holding encoded instruction words. The head word is
// visible combinationally on rdata so the write port can present it in the
// same cycle it becomes valid. Push while full and pop while empty are
// ignored.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   : enqueue wdata
//   pop           : dequeue the head word
//   rdata         : head word (undefined while empty)
//   full, empty   : occupancy flags
// ---------------------------------------------------------------------------
module inst_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_reg];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + (PTR_W+1)'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/instruction_encoder.sv
// ---------------------------------------------------------------------------
// instruction_encoder
// Encodes a stream of symbolic instructions into RV32I machine words and
// writes them sequentially into instruction memory from a start address.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start, start_addr        : begin a load (IDLE only) at start_addr
//   in_valid/in_ready        : request handshake
//   in_inst, in_rd, in_rs1, in_rs2, in_imm, in_last : request payload
//   mem_we/mem_ready         : IMEM write handshake
//   mem_addr, mem_wdata      : IMEM word address and encoded word
//   busy, done               : FSM status (done pulses for one cycle)
//   err_invalid              : sticky, an INVALID instruction was submitted
//   words_written            : words written since the last start
// ---------------------------------------------------------------------------
module instruction_encoder
    import common_def::*;
#(
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  instruction_type   in_inst,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_invalid,
    output logic [ADDR_W:0]   words_written
);

    enc_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W:0]   words_reg;
    logic              err_reg;

    logic              fifo_full, fifo_empty;
    logic [31:0]       fifo_head;
    logic              accept, push, write_fire;

    inst_fmt_t         fmt;
    logic [6:0]        opc, f7;
    logic [2:0]        f3;
    logic [31:0]       enc_word;

    assign accept     = in_valid && in_ready;
    // INVALID requests complete the handshake but never reach the FIFO.
    assign push       = accept && (in_inst != INVALID);
    assign write_fire = mem_we && mem_ready;

    inst_word_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (enc_word),
        .pop   (write_fire),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Field selection: format, opcode and function fields per instruction.
    always_comb begin
        fmt = FMT_FIXED;
        opc = OPC_OPIMM;
        f3  = '0;
        f7  = F7_BASE;
        case (in_inst)
            LUI:   begin fmt = FMT_U; opc = OPC_LUI; end
            AUIPC: begin fmt = FMT_U; opc = OPC_AUIPC; end
            JAL:   begin fmt = FMT_J; opc = OPC_JAL; end
            JALR:  begin fmt = FMT_I; opc = OPC_JALR; f3 = F3_JALR; end
            BEQ:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BEQ; end
            BNE:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BNE; end
            BLT:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BLT; end
            BGE:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BGE; end
            BLTU:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BLTU; end
            BGEU:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BGEU; end
            LB:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_B; end
            LH:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_H; end
            LW:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_W; end
            LBU:   begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_BU; end
            LHU:   begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_HU; end
            SB:    begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_B; end
            SH:    begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_H; end
            SW:    begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_W; end
            ADDI:  begin fmt = FMT_I; opc = OPC_OPIMM; f3 = F3_ADD_SUB; end
            SLTI:  begin fmt = FMT_I; opc = OPC_OPIMM; f3 = F3_SLT; end
            SLTIU: begin fmt = FMT_I; opc = OPC_OPIMM; f3 = F3_SLTU; end
            XORI:  begin fmt = FMT_I; opc = OPC_OPIMM; f3 = F3_XOR; end
            ORI:   begin fmt = FMT_I; opc = OPC_OPIMM; f3 = F3_OR; end
            ANDI:  begin fmt = FMT_I; opc = OPC_OPIMM; f3 = F3_AND; end
            SLLI:  begin fmt = FMT_SH; opc = OPC_OPIMM; f3 = F3_SLL; end
            SRLI:  begin fmt = FMT_SH; opc = OPC_OPIMM; f3 = F3_SRL_SRA; end
            SRAI:  begin fmt = FMT_SH; opc = OPC_OPIMM; f3 = F3_SRL_SRA; f7 = F7_ALT; end
            ADD:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_ADD_SUB; end
            SUB:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_ADD_SUB; f7 = F7_ALT; end
            SLL:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_SLL; end
            SLT:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_SLT; end
            SLTU:  begin fmt = FMT_R; opc = OPC_OP; f3 = F3_SLTU; end
            XOR:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_XOR; end
            SRL:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_SRL_SRA; end
            SRA:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_SRL_SRA; f7 = F7_ALT; end
            OR:    begin fmt = FMT_R; opc = OPC_OP; f3 = F3_OR; end
            AND:   begin fmt = FMT_R; opc = OPC_OP; f3 = F3_AND; end
            default: begin fmt = FMT_FIXED; end
        endcase
    end

    // Word assembly. Each format only pulls the fields it owns, so unused
    // register/immediate bits fall out as zero.
    always_comb begin
        enc_word = '0;
        case (fmt)
            FMT_R:  enc_word = {f7, in_rs2, in_rs1, f3, in_rd, opc};
            FMT_I:  enc_word = {in_imm[11:0], in_rs1, f3, in_rd, opc};
            FMT_SH: enc_word = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
            FMT_S:  enc_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
            FMT_B:  enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                                in_imm[4:1], in_imm[11], opc};
            FMT_U:  enc_word = {in_imm[31:12], in_rd, opc};
            FMT_J:  enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                in_rd, opc};
            default: begin
                if (in_inst == NOP) begin
                    enc_word = NOP_WORD;
                end else if (in_inst == ECALL) begin
                    enc_word = ECALL_WORD;
                end
            end
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ACTIVE;
            ACTIVE:  if (accept && in_last) state_next = DRAIN;
            // An empty FIFO means mem_we is low, so no write is outstanding.
            DRAIN:   if (fifo_empty) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            words_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == IDLE) && start) begin
                addr_reg  <= start_addr;
                words_reg <= '0;
            end else if (write_fire) begin
                addr_reg  <= addr_reg + ADDR_W'(1);
                words_reg <= words_reg + (ADDR_W+1)'(1);
            end
            if (accept && (in_inst == INVALID)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign in_ready      = (state_reg == ACTIVE) && !fifo_full;
    assign mem_we        = !fifo_empty;
    assign mem_addr      = addr_reg;
    // Gated so the data bus reads as zero whenever nothing is offered.
    assign mem_wdata     = fifo_empty ? 32'h0 : fifo_head;
    assign busy          = (state_reg != IDLE);
    assign done          = (state_reg == DONE);
    assign err_invalid   = err_reg;
    assign words_written = words_reg;

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;
    import common_def::*;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    instruction_type   in_inst = NOP;
    logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0]       in_imm = '0;
    logic              in_last = 1'b0;
    logic              mem_we;
    logic              mem_ready = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy, done, err_invalid;
    logic [ADDR_W:0]   words_written;

    int tests = 0;
    int fails = 0;
    logic [ADDR_W-1:0] waddr_q[$];
    logic [31:0]       wdata_q[$];

    instruction_encoder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .mem_we(mem_we), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .err_invalid(err_invalid), .words_written(words_written)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, so the negedge sees what the next edge uses.
    always @(negedge clk) begin
        if (!rst && mem_we && mem_ready) begin
            waddr_q.push_back(mem_addr);
            wdata_q.push_back(mem_wdata);
            $display("[TB] write addr=%h data=%h", mem_addr, mem_wdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a);
        waddr_q.delete();
        wdata_q.delete();
        start = 1'b1;
        start_addr = a;
        step();
        start = 1'b0;
    endtask

    task automatic send(input instruction_type inst, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last);
        bit got = 1'b0;
        in_valid = 1'b1; in_inst = inst; in_rd = rd; in_rs1 = rs1;
        in_rs2 = rs2; in_imm = imm; in_last = last;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL send_accept %s: in_ready=0 expected 1 within 40 cycles", inst.name());
        end
        step();
        in_valid = 1'b0;
        in_last = 1'b0;
        $display("[TB] request %s rd=%0d rs1=%0d rs2=%0d imm=%h last=%0d",
                 inst.name(), rd, rs1, rs2, imm, last);
    endtask

    task automatic wait_done(output int cyc);
        bit got = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                cyc = i;
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL done_pulse: done=0 expected 1 within 60 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        @(negedge clk);
        tests++;
        if ({mem_we, busy, done, in_ready, err_invalid} !== 5'b0 ||
            mem_addr !== '0 || mem_wdata !== 32'h0 || words_written !== '0) begin
            fails++;
            $display("FAIL reset_outputs: we=%b busy=%b done=%b rdy=%b err=%b addr=%h wd=%h ww=%0d expected all 0",
                     mem_we, busy, done, in_ready, err_invalid, mem_addr, mem_wdata, words_written);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single();
        int cyc;
        mem_ready = 1'b1;
        do_start(12'h010);
        send(ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        @(negedge clk);
        tests++;
        if (mem_we !== 1'b1 || mem_addr !== 12'h010 || mem_wdata !== 32'h00500093 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_write: we=%b addr=%h data=%h busy=%b expected 1 010 00500093 1",
                     mem_we, mem_addr, mem_wdata, busy);
        end
        wait_done(cyc);
        tests++;
        if (cyc != 2) begin
            fails++;
            $display("FAIL single_done_latency: %0d cycles expected 2", cyc);
        end
        tests++;
        if (words_written !== 13'd1) begin
            fails++;
            $display("FAIL single_words: %0d expected 1", words_written);
        end
        step();
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_idle: done=%b busy=%b expected 0 0", done, busy);
        end
        step();
    endtask

    task automatic test_stream();
        int cyc;
        logic [31:0] exp_d [4] = '{32'h0020A423, 32'h123452B7, 32'hFE208EE3, 32'h40725193};
        mem_ready = 1'b1;
        do_start(12'h020);
        send(SW,   5'd0, 5'd1, 5'd2, 32'd8,        1'b0);
        send(LUI,  5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0);
        send(BEQ,  5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0);
        send(SRAI, 5'd3, 5'd4, 5'd0, 32'd7,        1'b1);
        wait_done(cyc);
        tests++;
        if (wdata_q.size() != 4) begin
            fails++;
            $display("FAIL stream_count: %0d writes expected 4", wdata_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (i >= wdata_q.size()) begin
                fails++;
                $display("FAIL stream_word%0d: missing expected %h", i, exp_d[i]);
            end else if (wdata_q[i] !== exp_d[i] || waddr_q[i] !== 12'(12'h020 + i)) begin
                fails++;
                $display("FAIL stream_word%0d: addr=%h data=%h expected addr=%h data=%h",
                         i, waddr_q[i], wdata_q[i], 12'(12'h020 + i), exp_d[i]);
            end
        end
        step();
        step();
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit got = 1'b0;
        mem_ready = 1'b0;
        do_start(12'h100);
        send(ADDI, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
        // start while busy must not move the address counter
        start = 1'b1; start_addr = 12'h555;
        step();
        start = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            send(ADDI, 5'd1, 5'd0, 5'd0, 32'(k), 1'b0);
        end
        in_valid = 1'b1; in_inst = ADDI; in_rd = 5'd1; in_rs1 = '0; in_rs2 = '0;
        in_imm = 32'd5; in_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 12'h100 || mem_wdata !== 32'h00100093) begin
                fails++;
                $display("FAIL stall_cycle%0d: rdy=%b we=%b addr=%h data=%h expected 0 1 100 00100093",
                         k, in_ready, mem_we, mem_addr, mem_wdata);
            end
        end
        step();
        mem_ready = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL stall_release: in_ready=0 expected 1 after drain starts");
        end
        step();
        in_valid = 1'b0;
        in_last = 1'b0;
        wait_done(cyc);
        tests++;
        if (wdata_q.size() != 5) begin
            fails++;
            $display("FAIL drain_count: %0d writes expected 5", wdata_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (i >= wdata_q.size()) begin
                fails++;
                $display("FAIL drain_word%0d: missing", i);
            end else if (wdata_q[i] !== (32'((i + 1) << 20) | 32'h93) || waddr_q[i] !== 12'(12'h100 + i)) begin
                fails++;
                $display("FAIL drain_word%0d: addr=%h data=%h expected addr=%h data=%h", i,
                         waddr_q[i], wdata_q[i], 12'(12'h100 + i), 32'((i + 1) << 20) | 32'h93);
            end
        end
        step();
        step();
    endtask

    task automatic test_wrap();
        int cyc;
        mem_ready = 1'b1;
        do_start(12'hFFF);
        send(JAL, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0);
        send(ADD, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1);
        wait_done(cyc);
        tests++;
        if (words_written !== 13'd2) begin
            fails++;
            $display("FAIL wrap_words: %0d expected 2", words_written);
        end
        tests++;
        if (wdata_q.size() != 2 || waddr_q[0] !== 12'hFFF || waddr_q[1] !== 12'h000 ||
            wdata_q[0] !== 32'h008000EF || wdata_q[1] !== 32'h002081B3) begin
            fails++;
            $display("FAIL wrap_writes: n=%0d first=%h:%h second=%h:%h expected FFF:008000EF 000:002081B3",
                     wdata_q.size(), waddr_q[0], wdata_q[0], waddr_q[1], wdata_q[1]);
        end
        step();
        step();
    endtask

    task automatic test_invalid();
        int cyc;
        mem_ready = 1'b1;
        do_start(12'h040);
        send(NOP,     5'd5, 5'd3, 5'd2, 32'h7FF, 1'b0);
        send(INVALID, 5'd1, 5'd1, 5'd1, 32'h1,   1'b0);
        send(NOP,     5'd0, 5'd0, 5'd0, 32'h0,   1'b1);
        wait_done(cyc);
        tests++;
        if (err_invalid !== 1'b1 || words_written !== 13'd2) begin
            fails++;
            $display("FAIL invalid_status: err=%b words=%0d expected 1 2", err_invalid, words_written);
        end
        tests++;
        if (wdata_q.size() != 2 || wdata_q[0] !== NOP_WORD || wdata_q[1] !== NOP_WORD ||
            waddr_q[0] !== 12'h040 || waddr_q[1] !== 12'h041) begin
            fails++;
            $display("FAIL invalid_writes: n=%0d expected 2 NOP words at 040,041", wdata_q.size());
        end
        step();
        step();
        @(negedge clk);
        tests++;
        if (err_invalid !== 1'b1) begin
            fails++;
            $display("FAIL invalid_sticky: err=%b expected 1", err_invalid);
        end
        step();
        // INVALID carrying in_last still ends the load
        do_start(12'h050);
        send(ECALL,   5'd7, 5'd1, 5'd2, 32'h1, 1'b0);
        send(INVALID, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1);
        wait_done(cyc);
        tests++;
        if (wdata_q.size() != 1 || wdata_q[0] !== ECALL_WORD || waddr_q[0] !== 12'h050) begin
            fails++;
            $display("FAIL invalid_last: n=%0d data=%h expected 1 write of 00000073 at 050",
                     wdata_q.size(), wdata_q[0]);
        end
        step();
        step();
    endtask

    task automatic test_reset_midload();
        int cyc;
        bit stray = 1'b0;
        mem_ready = 1'b0;
        do_start(12'h200);
        for (int k = 1; k <= 3; k++) begin
            send(ADDI, 5'd2, 5'd0, 5'd0, 32'(k), 1'b0);
        end
        rst = 1'b1;
        step();
        @(negedge clk);
        tests++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || err_invalid !== 1'b0 ||
            words_written !== '0 || mem_addr !== '0) begin
            fails++;
            $display("FAIL midload_reset: we=%b busy=%b rdy=%b err=%b ww=%0d addr=%h expected all 0",
                     mem_we, busy, in_ready, err_invalid, words_written, mem_addr);
        end
        step();
        rst = 1'b0;
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_we !== 1'b0) stray = 1'b1;
        end
        tests++;
        if (stray) begin
            fails++;
            $display("FAIL midload_no_write: mem_we=1 seen expected 0 after reset");
        end
        step();
        do_start(12'h300);
        send(ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        wait_done(cyc);
        tests++;
        if (wdata_q.size() != 1 || wdata_q[0] !== 32'h00500093 || waddr_q[0] !== 12'h300 ||
            words_written !== 13'd1) begin
            fails++;
            $display("FAIL restart: n=%0d data=%h addr=%h ww=%0d expected 1 00500093 300 1",
                     wdata_q.size(), wdata_q[0], waddr_q[0], words_written);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_back_to_back();
        test_wrap();
        test_invalid();
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
